spi_frame_receiver: RTL and testbench

SPI_FRAME_RECEIVER -- requirements
Module: spi_frame_receiver

---
 rtl/spi_frame_receiver_pkg.sv | 39 +++
 rtl/spi_sync_edge.sv | 34 +++
 rtl/spi_frame_receiver.sv | 149 ++++++++++++++
 tb/tb_spi_frame_receiver.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_frame_receiver_pkg.sv
// Shared definitions for the SPI frame receiver and its DAC transmitter peer:
// frame layout, field positions, FSM states.
package spi_frame_receiver_pkg;

    localparam int unsigned FRAME_BITS = 32;
    localparam int unsigned CNT_W      = 6;

    localparam int unsigned PREFIX_W = 8;
    localparam int unsigned CMD_W    = 4;
    localparam int unsigned ADDR_W   = 4;
    localparam int unsigned DATA_W   = 12;
    localparam int unsigned PAD_W    = 4;

    localparam int unsigned PREFIX_LSB = 24;
    localparam int unsigned CMD_LSB    = 20;
    localparam int unsigned ADDR_LSB   = 16;
    localparam int unsigned DATA_LSB   = 4;
    localparam int unsigned PAD_LSB    = 0;

    localparam logic [PREFIX_W-1:0] PREFIX_VAL = 8'hFF;
    localparam logic [PAD_W-1:0]    PAD_VAL    = 4'h0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Frame as shifted in, MSB first: prefix occupies the top byte
    typedef struct packed {
        logic [PREFIX_W-1:0] prefix;
        logic [CMD_W-1:0]    cmd;
        logic [ADDR_W-1:0]   addr;
        logic [DATA_W-1:0]   data;
        logic [PAD_W-1:0]    pad;
    } frame_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input plus rise/fall detection
// between the last stage and the stage before it.
module spi_sync_edge #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise_c,
    output logic fall_c
);

    // sync_q[0] is the newest sample, sync_q[STAGES-1] the settled one
    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], din};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign level  = sync_q[STAGES-1];
    assign rise_c = sync_q[STAGES-2] & ~sync_q[STAGES-1];
    assign fall_c = ~sync_q[STAGES-2] & sync_q[STAGES-1];

endmodule

// File: rtl/spi_frame_receiver.sv
// SPI write-frame receiver: shifts 32-bit frames, validates cmd/addr and
// publishes the 12-bit data field. Define SPI_FRAME_CHECK_EN to also enforce prefix/pad.
module spi_frame_receiver
    import spi_frame_receiver_pkg::*;
#(
    parameter logic [CMD_W-1:0]  EXP_COMMAND = 4'b0011,
    parameter logic [ADDR_W-1:0] EXP_ADDR    = 4'b0000,
    parameter int unsigned       SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sck,
    input  logic              mosi,
    input  logic              cs_n,
    output logic [DATA_W-1:0] sample,
    output logic              sample_valid,
    output logic              frame_err,
    output logic              busy
);

    logic sck_lvl, sck_rise_c, sck_fall_c;
    logic mosi_lvl, mosi_rise_c, mosi_fall_c;
    logic cs_lvl, cs_rise_c, cs_fall_c;

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sck_sync (
        .clk(clk), .rst(rst), .din(sck),
        .level(sck_lvl), .rise_c(sck_rise_c), .fall_c(sck_fall_c)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_mosi_sync (
        .clk(clk), .rst(rst), .din(mosi),
        .level(mosi_lvl), .rise_c(mosi_rise_c), .fall_c(mosi_fall_c)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_cs_sync (
        .clk(clk), .rst(rst), .din(cs_n),
        .level(cs_lvl), .rise_c(cs_rise_c), .fall_c(cs_fall_c)
    );

    logic edges_unused_c;
    assign edges_unused_c = ^{sck_lvl, sck_fall_c, mosi_rise_c, mosi_fall_c, cs_lvl};

    state_t                  state_q, state_d;
    logic [FRAME_BITS-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0]       sample_q, sample_d;
    logic                    valid_q, valid_d;
    logic                    err_q, err_d;
    logic                    busy_q, busy_d;
    logic                    ovr_q, ovr_d;

    frame_t frame_c;
    logic   frame_ok_c;

    assign frame_c = frame_t'(shift_q);

`ifdef SPI_FRAME_CHECK_EN
    assign frame_ok_c = (frame_c.cmd == EXP_COMMAND) && (frame_c.addr == EXP_ADDR) &&
                        (frame_c.prefix == PREFIX_VAL) && (frame_c.pad == PAD_VAL);
`else
    assign frame_ok_c = (frame_c.cmd == EXP_COMMAND) && (frame_c.addr == EXP_ADDR);

    logic frame_unused_c;
    assign frame_unused_c = ^{frame_c.prefix, frame_c.pad};
`endif

    // Next-state and output decode; cs_n rising always wins over a coincident sck edge
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        sample_d = sample_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        ovr_d    = ovr_q;

        case (state_q)
            ST_IDLE: begin
                if (cs_fall_c) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                end
            end
            ST_SHIFT: begin
                if (cs_rise_c) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else if (sck_rise_c) begin
                    shift_d = {shift_q[FRAME_BITS-2:0], mosi_lvl};
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(FRAME_BITS - 1)) begin
                        state_d = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                valid_d = frame_ok_c;
                err_d   = ~frame_ok_c;
                ovr_d   = 1'b0;
                if (frame_ok_c) begin
                    sample_d = frame_c.data;
                end
                state_d = cs_rise_c ? ST_IDLE : ST_DONE;
            end
            ST_DONE: begin
                if (cs_rise_c) begin
                    state_d = ST_IDLE;
                end else if (sck_rise_c && !ovr_q) begin
                    err_d = 1'b1;
                    ovr_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // CHECK is a one-cycle hop inside the frame, so busy stays continuous through it
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            shift_q  <= '0;
            cnt_q    <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            ovr_q    <= ovr_d;
        end
    end

    assign sample       = sample_q;
    assign sample_valid = valid_q;
    assign frame_err    = err_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_spi_frame_receiver.sv
// Directed bench for spi_frame_receiver with a frame-level reference model.
module tb_spi_frame_receiver;

    localparam int unsigned SYNC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        sck;
    logic        mosi;
    logic        cs_n;
    logic [11:0] sample;
    logic        sample_valid;
    logic        frame_err;
    logic        busy;

    always #5 clk = ~clk;

    spi_frame_receiver #(
        .EXP_COMMAND(4'b0011),
        .EXP_ADDR   (4'b0000),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sck         (sck),
        .mosi        (mosi),
        .cs_n        (cs_n),
        .sample      (sample),
        .sample_valid(sample_valid),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rise_cyc = 0;
    int valid_cyc = -1;
    int n_valid = 0;
    int n_err = 0;

    // Model state: pulses still owed by the DUT and the value sample must hold
    int          exp_valid = 0;
    int          exp_err = 0;
    logic [11:0] model_sample = 12'h000;
    logic [11:0] pend_sample = 12'h000;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic bit frame_accepted(input logic [31:0] w);
        int unsigned cmd, addr;
        bit ok;
        cmd  = (w >> 20) & 32'hF;
        addr = (w >> 16) & 32'hF;
        ok   = (cmd == 3) && (addr == 0);
`ifdef SPI_FRAME_CHECK_EN
        ok = ok && ((w >> 24) == 32'hFF) && ((w & 32'hF) == 0);
`endif
        return ok;
    endfunction

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sck_bit(input logic b);
        mosi = b;
        wait_neg(4);
        sck      = 1'b1;
        rise_cyc = cyc;
        wait_neg(4);
        sck = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] w, input int nbits);
        if (nbits < 32) begin
            exp_err++;
        end else begin
            if (frame_accepted(w)) begin
                exp_valid++;
                pend_sample = 12'((w >> 4) & 32'hFFF);
            end else begin
                exp_err++;
            end
            if (nbits > 32) exp_err++;
        end
        cs_n = 1'b0;
        wait_neg(4);
        for (int i = 0; i < nbits; i++) begin
            if (i < 32) sck_bit(w[5'(31 - i)]);
            else        sck_bit(1'b0);
            if (i == 7) check("busy_mid_frame", 32'(busy), 32'd1);
        end
        wait_neg(4);
        cs_n = 1'b1;
        wait_neg(10);
        check("valid_pulses_owed", 32'(exp_valid), 32'd0);
        check("err_pulses_owed", 32'(exp_err), 32'd0);
        check("busy_after_frame", 32'(busy), 32'd0);
        exp_valid = 0;
        exp_err   = 0;
    endtask

    // Cycle-by-cycle comparison against the model, 1 time unit after each rising edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            check("valid_err_exclusive", 32'(sample_valid & frame_err), 32'd0);
            if (sample_valid) begin
                valid_cyc = cyc;
                n_valid++;
                check("valid_expected", 32'(exp_valid > 0), 32'd1);
                check("sample_on_valid", 32'(sample), 32'(pend_sample));
                model_sample = pend_sample;
                if (exp_valid > 0) exp_valid--;
            end else begin
                check("sample_hold", 32'(sample), 32'(model_sample));
            end
            if (frame_err) begin
                n_err++;
                check("err_expected", 32'(exp_err > 0), 32'd1);
                if (exp_err > 0) exp_err--;
            end
        end
    end

    initial begin
        int v0, e0;
        rst  = 1'b0;
        sck  = 1'b0;
        mosi = 1'b0;
        cs_n = 1'b1;
        wait_neg(3);
        check("rst_sample", 32'(sample), 32'h000);
        check("rst_valid", 32'(sample_valid), 32'd0);
        check("rst_err", 32'(frame_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        wait_neg(5);

        // sck toggling with cs_n high must be ignored
        e0 = n_err; v0 = n_valid;
        repeat (3) sck_bit(1'b1);
        wait_neg(8);
        check("idle_sck_no_pulse", 32'((n_err - e0) + (n_valid - v0)), 32'd0);
        check("idle_sck_busy", 32'(busy), 32'd0);

        // Good frame
        e0 = n_err; v0 = n_valid;
        send_frame(32'hFF30ABC0, 32);
        check("good_sample", 32'(sample), 32'h0ABC);
        check("good_valid_cnt", 32'(n_valid - v0), 32'd1);
        check("good_err_cnt", 32'(n_err - e0), 32'd0);
        check("good_latency", 32'(valid_cyc - rise_cyc), 32'(SYNC + 1));

        // Wrong command
        e0 = n_err; v0 = n_valid;
        send_frame(32'hFF40ABC0, 32);
        check("badcmd_sample", 32'(sample), 32'h0ABC);
        check("badcmd_err_cnt", 32'(n_err - e0), 32'd1);
        check("badcmd_valid_cnt", 32'(n_valid - v0), 32'd0);

        // Aborted after 20 bits, then a good frame
        e0 = n_err; v0 = n_valid;
        send_frame(32'hFF30ABC0, 20);
        check("abort_err_cnt", 32'(n_err - e0), 32'd1);
        check("abort_sample", 32'(sample), 32'h0ABC);
        send_frame(32'hFF300010, 32);
        check("after_abort_sample", 32'(sample), 32'h001);

        // Overrun: 33 sck edges
        e0 = n_err; v0 = n_valid;
        send_frame(32'hFF30FFF0, 33);
        check("overrun_sample", 32'(sample), 32'h0FFF);
        check("overrun_valid_cnt", 32'(n_valid - v0), 32'd1);
        check("overrun_err_cnt", 32'(n_err - e0), 32'd1);

        // Bad prefix: rejected only with prefix checking enabled
        e0 = n_err; v0 = n_valid;
        send_frame(32'hFE30ABC0, 32);
`ifdef SPI_FRAME_CHECK_EN
        check("prefix_sample", 32'(sample), 32'h0FFF);
        check("prefix_err_cnt", 32'(n_err - e0), 32'd1);
`else
        check("prefix_sample", 32'(sample), 32'h0ABC);
        check("prefix_valid_cnt", 32'(n_valid - v0), 32'd1);
`endif

        // Reset mid-frame after 16 bits
        e0 = n_err; v0 = n_valid;
        cs_n = 1'b0;
        wait_neg(4);
        for (int i = 0; i < 16; i++) sck_bit(i[0]);
        rst = 1'b0;
        model_sample = 12'h000;
        wait_neg(2);
        check("midrst_sample", 32'(sample), 32'h000);
        check("midrst_valid", 32'(sample_valid), 32'd0);
        check("midrst_err", 32'(frame_err), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        wait_neg(2);
        cs_n = 1'b1;
        wait_neg(8);
        check("midrst_no_pulse", 32'((n_err - e0) + (n_valid - v0)), 32'd0);
        send_frame(32'hFF301230, 32);
        check("after_rst_sample", 32'(sample), 32'h123);
        check("after_rst_valid_cnt", 32'(n_valid - v0), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
